debug_sequencer: RTL
====================

Name: debug_sequencer

Overview:
- Sequences the pipelined datapath for the debug host.
- Gates pipeline advance through a global enable in three modes:
  - continuous run until the halt instruction,
  - single-step,
  - frozen.
- After each run, step, or explicit request, snapshots PC, cycle count and the 32-entry register file debug bus. Streams the snapshot out bytewise over a valid/ready byte interface toward the UART transmitter.
- Command bytes arrive from the UART receiver.

Parameters:
- PROC_BITS, 32, register width; must be a multiple of 8.
- PC_BITS, 32, PC width; must be a multiple of 8.
- NUM_REGS, 32, register file entries in the debug bus.
- CNT_BITS, 32, cycle counter width; must be a multiple of 8.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-low reset.
- i_cmd_valid, input, 1, command byte present.
- i_cmd, input, 8, command byte.
- o_cmd_ready, output, 1, command byte is consumed this cycle when high together with i_cmd_valid.
- i_halt, input, 1, level; the halt instruction has reached writeback.
- i_pc, input, PC_BITS, current PC.
- i_rf_regs, input, NUM_REGS*PROC_BITS, register file debug bus; reg k occupies bits [k*PROC_BITS +: PROC_BITS].
- o_pipe_enable, output, 1, registered; pipeline registers and PC advance only when high.
- o_tx_valid, output, 1, byte available.
- o_tx_data, output, 8, byte to transmit.
- i_tx_ready, input, 1, sink accepts the byte.
- o_busy, output, 1, high in every state except IDLE.
- o_cycle_count, output, CNT_BITS, number of enabled cycles since reset.

Behaviour:
Reset values (asynchronous on rst=0): state IDLE, o_pipe_enable=0, o_tx_valid=0, o_tx_data=0, o_cycle_count=0, o_busy=0, byte index=0.

Command codes:
- 0x01 RUN
- 0x02 STEP
- 0x03 DUMP
- 0x04 STOP
- All other codes are consumed and ignored.

o_cmd_ready rule: o_cmd_ready = (state==IDLE) || (state==RUN). A command is accepted on the edge where i_cmd_valid && o_cmd_ready.

States:
- IDLE
  - o_pipe_enable=0.
  - RUN with i_halt=0 -> RUN.
  - STEP with i_halt=0 -> STEP.
  - DUMP -> SNAP.
  - RUN or STEP while i_halt=1 is consumed and ignored.
  - STOP is ignored.
- RUN
  - o_pipe_enable=1 on the cycle after entry.
  - Exits to SNAP when i_halt=1 or a STOP is accepted; o_pipe_enable=0 from the following cycle.
  - Halt and STOP in the same cycle is a single exit to SNAP.
  - RUN, STEP and DUMP received in RUN are consumed and ignored.
- STEP
  - o_pipe_enable=1 for exactly one cycle, then SNAP.
- SNAP
  - One cycle; latches i_pc, o_cycle_count and i_rf_regs into the snapshot register. Pipeline is frozen, so these values are final.
  - Then -> SEND.
- SEND
  - Streams 8+NUM_REGS*PROC_BITS/8 bytes; 136 with default parameters.
  - Order: PC, then cycle count, then reg0..reg(NUM_REGS-1). Each word is sent least-significant byte first.
  - o_tx_valid=1 throughout SEND.
  - o_tx_data is held stable until i_tx_ready=1; the index advances on each handshake.
  - On handshake of the last byte -> IDLE with o_tx_valid=0 in the next cycle.

Cycle counter:
- Increments on every cycle with o_pipe_enable=1.
- Saturates at all-ones.
- Cleared only by reset.

Latency:
- Command accept to first o_pipe_enable=1: 1 cycle.
- STEP to first o_tx_valid: 3 cycles (STEP, SNAP, SEND).

Boundary conditions:
- i_halt asserted during the STEP cycle: the step completes normally.
- Reset asserted mid-SEND: streaming aborts immediately and the block returns to reset values; no partial-frame resume.
- i_tx_ready held low: SEND stalls indefinitely, o_pipe_enable stays 0, and commands are not accepted.

Test Plan:
- Reset: rst=0 during SEND -> next sample shows o_tx_valid=0, o_busy=0, o_cycle_count=0, o_pipe_enable=0.
- STEP from reset with i_pc=0x00000004 and reg k=k, i_tx_ready=1:
  - o_pipe_enable high exactly 1 cycle.
  - 136 bytes follow: 04 00 00 00, 01 00 00 00, then 00 00 00 00, 01 00 00 00, ..., 1F 00 00 00.
  - Back to IDLE.
- RUN, with i_halt raised 10 cycles after o_pipe_enable rises:
  - o_pipe_enable high for 11 cycles.
  - Frame reports cycle count 0x0000000B.
  - A subsequent RUN with i_halt=1 is consumed, with no enable pulse.
- RUN then STOP after 5 enabled cycles -> enable drops the cycle after the accept; frame count 5; RUN/STEP/DUMP sent during RUN are accepted but have no effect.
- Backpressure: DUMP with i_tx_ready toggling 1,0,0,1... -> o_tx_data unchanged across stalled cycles; exactly 136 handshakes; o_cmd_ready=0 throughout SEND.
- STOP and i_halt in the same RUN cycle -> exactly one frame of 136 bytes; unknown command 0x7F in IDLE -> consumed, state stays IDLE.

Source files
------------

// File: rtl/debug_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : debug_sequencer
//  Description : Debug-host sequencer for a pipelined datapath. Gates the
//                pipeline through a registered enable (run / single-step /
//                frozen), snapshots PC, cycle count and the register file
//                debug bus, and streams the snapshot bytewise toward a UART
//                transmitter over a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_sequencer #(
    parameter int PROC_BITS = 32,
    parameter int PC_BITS   = 32,
    parameter int NUM_REGS  = 32,
    parameter int CNT_BITS  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_cmd_valid,
    input  logic [7:0]                    i_cmd,
    output logic                          o_cmd_ready,
    input  logic                          i_halt,
    input  logic [PC_BITS-1:0]            i_pc,
    input  logic [NUM_REGS*PROC_BITS-1:0] i_rf_regs,
    output logic                          o_pipe_enable,
    output logic                          o_tx_valid,
    output logic [7:0]                    o_tx_data,
    input  logic                          i_tx_ready,
    output logic                          o_busy,
    output logic [CNT_BITS-1:0]           o_cycle_count
);

    // Snapshot layout, LSB first: PC, cycle count, reg0 .. reg(NUM_REGS-1).
    // Streaming the whole vector LSB-byte first therefore yields every word
    // least-significant byte first in the required order.
    localparam int c_SNAP_BITS = PC_BITS + CNT_BITS + NUM_REGS * PROC_BITS;
    localparam int c_NUM_BYTES = c_SNAP_BITS / 8;
    localparam int c_IDX_BITS  = (c_NUM_BYTES > 1) ? $clog2(c_NUM_BYTES) : 1;

    localparam logic [c_IDX_BITS-1:0] c_LAST_IDX = c_IDX_BITS'(c_NUM_BYTES - 1);
    localparam logic [CNT_BITS-1:0]   c_CNT_MAX  = {CNT_BITS{1'b1}};

    localparam logic [7:0] c_CMD_RUN  = 8'h01;
    localparam logic [7:0] c_CMD_STEP = 8'h02;
    localparam logic [7:0] c_CMD_DUMP = 8'h03;
    localparam logic [7:0] c_CMD_STOP = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_STEP = 3'd2,
        S_SNAP = 3'd3,
        S_SEND = 3'd4
    } state_t;

    state_t                  r_state;
    logic                    r_pipe_enable;
    logic [CNT_BITS-1:0]     r_cycle_count;
    logic [c_SNAP_BITS-1:0]  r_snap;
    logic [c_IDX_BITS-1:0]   r_byte_idx;

    logic                    w_cmd_accept;
    logic                    w_stop_accept;

    // Commands are only taken while the pipeline can react to them.
    assign o_cmd_ready   = (r_state == S_IDLE) || (r_state == S_RUN);
    assign w_cmd_accept  = i_cmd_valid && o_cmd_ready;
    assign w_stop_accept = w_cmd_accept && (i_cmd == c_CMD_STOP);

    assign o_pipe_enable = r_pipe_enable;
    assign o_cycle_count = r_cycle_count;
    assign o_busy        = (r_state != S_IDLE);
    assign o_tx_valid    = (r_state == S_SEND);
    // The snapshot shifts down one byte per handshake, so the current byte
    // always sits at the bottom and stays put while the sink stalls.
    assign o_tx_data     = r_snap[7:0];

    // Sequencer FSM: owns state, pipeline enable, snapshot and byte index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_pipe_enable <= 1'b0;
            r_snap        <= '0;
            r_byte_idx    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pipe_enable <= 1'b0;
                    if (w_cmd_accept) begin
                        // RUN/STEP against a halted core are swallowed.
                        if ((i_cmd == c_CMD_RUN) && !i_halt) begin
                            r_state       <= S_RUN;
                            r_pipe_enable <= 1'b1;
                        end else if ((i_cmd == c_CMD_STEP) && !i_halt) begin
                            r_state       <= S_STEP;
                            r_pipe_enable <= 1'b1;
                        end else if (i_cmd == c_CMD_DUMP) begin
                            r_state <= S_SNAP;
                        end
                    end
                end

                S_RUN: begin
                    // Halt and STOP together still produce a single exit.
                    if (i_halt || w_stop_accept) begin
                        r_state       <= S_SNAP;
                        r_pipe_enable <= 1'b0;
                    end
                end

                S_STEP: begin
                    // Exactly one enabled cycle; a halt arriving now is
                    // simply part of the completed step.
                    r_state       <= S_SNAP;
                    r_pipe_enable <= 1'b0;
                end

                S_SNAP: begin
                    // Pipeline is frozen here, so the captured values are final.
                    r_snap     <= {i_rf_regs, r_cycle_count, i_pc};
                    r_byte_idx <= '0;
                    r_state    <= S_SEND;
                end

                S_SEND: begin
                    if (i_tx_ready) begin
                        r_snap <= {8'h00, r_snap[c_SNAP_BITS-1:8]};
                        if (r_byte_idx == c_LAST_IDX) begin
                            r_byte_idx <= '0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state       <= S_IDLE;
                    r_pipe_enable <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of enabled cycles; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_count <= '0;
        end else if (r_pipe_enable && (r_cycle_count != c_CNT_MAX)) begin
            r_cycle_count <= r_cycle_count + 1'b1;
        end
    end

endmodule
`default_nettype wire
